// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the sequential ALU.
//   - default operand width and MUL/DIV iteration count
//   - opcode encodings OP_ADD..OP_PASS
//   - flag bit positions inside the {Z,N,C,V} flag vector
//   - FSM state encoding (also visible on the debug state output)
package alu_pkg;

   localparam int ALU_WIDTH = 16;
   localparam int ALU_ITER  = 16;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOT  = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_SHR  = 4'd7;
   localparam logic [3:0] OP_MUL  = 4'd8;
   localparam logic [3:0] OP_DIVU = 4'd9;
   localparam logic [3:0] OP_PASS = 4'd10;

   localparam int FLG_Z = 3;
   localparam int FLG_N = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_ITER = 2'd2;
   localparam logic [1:0] ST_FIN  = 2'd3;

endpackage

// File: rtl/alu_iter.sv
// alu_iter: iterative datapath shared by unsigned MUL and DIVU.
// A {hi,lo} shift register plus one add/subtract adder.
//   MUL  : hi = partial product, lo = multiplier; right shift-add per step.
//   DIVU : hi = partial remainder, lo = dividend/quotient; restoring
//          subtract with left shift per step.
// After WIDTH steps: MUL -> {hi,lo} = product, DIVU -> hi = remainder,
// lo = quotient.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   i_init       load i_a into lo, i_b into the operand register, clear hi
//   i_step       perform one iteration
//   i_mode_div   1 = divide step, 0 = multiply step
//   i_a, i_b     multiplier/dividend, multiplicand/divisor
//   o_hi, o_lo   shift register halves
module alu_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_init,
   input  logic             i_step,
   input  logic             i_mode_div,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_b;

   logic [WIDTH:0]   w_a;
   logic [WIDTH:0]   w_bop;
   logic             w_cin;
   logic [WIDTH+1:0] w_sum;

   // Divide: a = {rem, next dividend bit}, computes a - b as a + ~b + 1;
   // the carry out (bit WIDTH+1) is set exactly when a >= b.
   // Multiply: a = {0, hi}, computes hi + multiplicand.
   always_comb begin
      w_a   = {1'b0, r_hi};
      w_bop = {1'b0, r_b};
      w_cin = 1'b0;
      if (i_mode_div) begin
         w_a   = {r_hi, r_lo[WIDTH-1]};
         w_bop = ~{1'b0, r_b};
         w_cin = 1'b1;
      end
      w_sum = {1'b0, w_a} + {1'b0, w_bop} + {{(WIDTH+1){1'b0}}, w_cin};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi <= '0;
         r_lo <= '0;
         r_b  <= '0;
      end else if (i_init) begin
         r_hi <= '0;
         r_lo <= i_a;
         r_b  <= i_b;
      end else if (i_step) begin
         if (i_mode_div) begin
            if (w_sum[WIDTH+1]) begin
               r_hi <= w_sum[WIDTH-1:0];
               r_lo <= {r_lo[WIDTH-2:0], 1'b1};
            end else begin
               r_hi <= w_a[WIDTH-1:0];
               r_lo <= {r_lo[WIDTH-2:0], 1'b0};
            end
         end else begin
            if (r_lo[0]) begin
               r_hi <= w_sum[WIDTH:1];
               r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
            end else begin
               r_hi <= {1'b0, r_hi[WIDTH-1:1]};
               r_lo <= {r_hi[0], r_lo[WIDTH-1:1]};
            end
         end
      end
   end

   assign o_hi = r_hi;
   assign o_lo = r_lo;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential 16-bit ALU fed by the Op1/Op2 registers.
// One operation per accepted start; single-cycle ops finish one edge after
// capture, MUL/DIVU iterate ITER steps and finish at the edge after that.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   i_alu_start           request, sampled only in IDLE
//   i_alu_opcode          operation select, captured with start
//   i_alu_op1/op2         operands, captured with start
//   o_alu_result          result / MUL low half / quotient
//   o_alu_result_hi       MUL high half / remainder, 0 otherwise
//   o_alu_flags           {Z,N,C,V}
//   o_alu_busy            operation in progress
//   o_alu_done            one-cycle pulse, outputs valid
//   o_alu_div_err         divide by zero, valid with done
//   o_dbg_state           current FSM state
// Handshake: start is taken only when busy is low (including the done
// cycle); busy rises the cycle after acceptance and falls with done.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int ITER  = ALU_ITER
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_alu_start,
   input  logic [3:0]       i_alu_opcode,
   input  logic [WIDTH-1:0] i_alu_op1,
   input  logic [WIDTH-1:0] i_alu_op2,
   output logic [WIDTH-1:0] o_alu_result,
   output logic [WIDTH-1:0] o_alu_result_hi,
   output logic [3:0]       o_alu_flags,
   output logic             o_alu_busy,
   output logic             o_alu_done,
   output logic             o_alu_div_err,
   output logic [1:0]       o_dbg_state
);

   localparam int CNT_W = $clog2(ITER + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

   logic [1:0]       r_state;
   logic [3:0]       r_opc;
   logic [WIDTH-1:0] r_op1;
   logic [WIDTH-1:0] r_op2;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_result_hi;
   logic [3:0]       r_flags;
   logic             r_busy;
   logic             r_done;
   logic             r_div_err;

   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_sub;
   logic [WIDTH:0]   w_shl;
   logic [WIDTH:0]   w_shr;
   logic [WIDTH-1:0] w_res;
   logic             w_c;
   logic             w_v;
   logic             w_div0;
   logic             w_is_iter;
   logic             w_init;
   logic             w_step;
   logic             w_mode_div;
   logic [WIDTH-1:0] w_it_hi;
   logic [WIDTH-1:0] w_it_lo;

   // Shifts carry one extra bit so the last bit shifted out lands in it;
   // a shift by 0 leaves that bit 0.
   assign w_add = {1'b0, r_op1} + {1'b0, r_op2};
   assign w_sub = {1'b0, r_op1} - {1'b0, r_op2};
   assign w_shl = {1'b0, r_op1} << r_op2[3:0];
   assign w_shr = {r_op1, 1'b0} >> r_op2[3:0];

   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (r_opc)
         OP_ADD: begin
            w_res = w_add[WIDTH-1:0];
            w_c   = w_add[WIDTH];
            w_v   = (r_op1[WIDTH-1] == r_op2[WIDTH-1]) &&
                    (w_add[WIDTH-1] != r_op1[WIDTH-1]);
         end
         OP_SUB: begin
            w_res = w_sub[WIDTH-1:0];
            w_c   = w_sub[WIDTH];  // borrow
            w_v   = (r_op1[WIDTH-1] != r_op2[WIDTH-1]) &&
                    (w_sub[WIDTH-1] != r_op1[WIDTH-1]);
         end
         OP_AND:  w_res = r_op1 & r_op2;
         OP_OR:   w_res = r_op1 | r_op2;
         OP_XOR:  w_res = r_op1 ^ r_op2;
         OP_NOT:  w_res = ~r_op1;
         OP_SHL: begin
            w_res = w_shl[WIDTH-1:0];
            w_c   = w_shl[WIDTH];
         end
         OP_SHR: begin
            w_res = w_shr[WIDTH:1];
            w_c   = w_shr[0];
         end
         OP_PASS: w_res = r_op2;
         default: w_res = '0;
      endcase
   end

   assign w_div0     = (r_opc == OP_DIVU) && (r_op2 == '0);
   assign w_is_iter  = (r_opc == OP_MUL) || ((r_opc == OP_DIVU) && !w_div0);
   assign w_mode_div = (r_opc == OP_DIVU);
   // The iterative datapath loads at capture, so EXEC already performs step 1.
   assign w_init     = (r_state == ST_IDLE) && i_alu_start;
   assign w_step     = ((r_state == ST_EXEC) && w_is_iter) || (r_state == ST_ITER);

   alu_iter #(.WIDTH(WIDTH)) u_iter (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_init     (w_init),
      .i_step     (w_step),
      .i_mode_div (w_mode_div),
      .i_a        (i_alu_op1),
      .i_b        (i_alu_op2),
      .o_hi       (w_it_hi),
      .o_lo       (w_it_lo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_opc       <= '0;
         r_op1       <= '0;
         r_op2       <= '0;
         r_cnt       <= '0;
         r_result    <= '0;
         r_result_hi <= '0;
         r_flags     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_div_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_alu_start) begin
                  r_opc   <= i_alu_opcode;
                  r_op1   <= i_alu_op1;
                  r_op2   <= i_alu_op2;
                  r_busy  <= 1'b1;
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (w_is_iter) begin
                  r_cnt   <= CNT_W'(1);
                  r_state <= ST_ITER;
               end else begin
                  if (w_div0) begin
                     r_result    <= '1;
                     r_result_hi <= r_op1;
                     r_flags     <= 4'b0100;  // {Z,N,C,V}: N only
                     r_div_err   <= 1'b1;
                  end else begin
                     r_result    <= w_res;
                     r_result_hi <= '0;
                     r_flags     <= {(w_res == '0), w_res[WIDTH-1], w_c, w_v};
                     r_div_err   <= 1'b0;
                  end
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            ST_ITER: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_LAST) begin
                  r_state <= ST_FIN;
               end
            end
            default: begin  // ST_FIN
               r_result         <= w_it_lo;
               r_result_hi      <= w_it_hi;
               r_flags[FLG_Z]   <= (w_it_lo == '0);
               r_flags[FLG_N]   <= w_it_lo[WIDTH-1];
               r_flags[FLG_C]   <= !w_mode_div && (w_it_hi != '0);
               r_flags[FLG_V]   <= !w_mode_div && (w_it_hi != '0);
               r_div_err        <= 1'b0;
               r_cnt            <= '0;
               r_done           <= 1'b1;
               r_busy           <= 1'b0;
               r_state          <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_alu_result    = r_result;
   assign o_alu_result_hi = r_result_hi;
   assign o_alu_flags     = r_flags;
   assign o_alu_busy      = r_busy;
   assign o_alu_done      = r_done;
   assign o_alu_div_err   = r_div_err;
   assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven vectors plus hand-written multi-cycle sequences.
// Expected {result, result_hi, flags, div_err} words are queued when an
// operation is issued and compared when done pulses.
module tb_alu_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  opcode;
   logic [15:0] op1;
   logic [15:0] op2;
   logic [15:0] result;
   logic [15:0] result_hi;
   logic [3:0]  flags;
   logic        busy;
   logic        done;
   logic        div_err;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   logic [36:0] exp_q[$];

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic [15:0] hi;
      logic [3:0]  flg;
      logic        err;
      int          lat;
   } vec_t;

   vec_t vecs[24];
   int   n_vec;

   alu_seq dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_alu_start     (start),
      .i_alu_opcode    (opcode),
      .i_alu_op1       (op1),
      .i_alu_op2       (op2),
      .o_alu_result    (result),
      .o_alu_result_hi (result_hi),
      .o_alu_flags     (flags),
      .o_alu_busy      (busy),
      .o_alu_done      (done),
      .o_alu_div_err   (div_err),
      .o_dbg_state     (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [36:0] pack_exp(input logic [15:0] r, input logic [15:0] h,
                                            input logic [3:0] f, input logic e);
      return {r, h, f, e};
   endfunction

   // Behavioural reference for random ADD/SUB/MUL/DIVU traffic.
   function automatic logic [36:0] model(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
      logic [15:0] r, h;
      logic        c, v, e;
      logic [31:0] p;
      r = 16'h0; h = 16'h0; c = 1'b0; v = 1'b0; e = 1'b0;
      case (op)
         4'd0: begin
            p = {16'h0, a} + {16'h0, b};
            r = p[15:0];
            c = p[16];
            v = (a[15] == b[15]) && (r[15] != a[15]);
         end
         4'd1: begin
            r = a - b;
            c = (a < b);
            v = (a[15] != b[15]) && (r[15] != a[15]);
         end
         4'd8: begin
            p = {16'h0, a} * {16'h0, b};
            r = p[15:0];
            h = p[31:16];
            c = (h != 16'h0);
            v = c;
         end
         default: begin
            if (b == 16'h0) begin
               r = 16'hFFFF; h = a; e = 1'b1;
            end else begin
               r = a / b; h = a % b;
            end
         end
      endcase
      return {r, h, (r == 16'h0), r[15], c, v, e};
   endfunction

   // Wait (bounded) for done, counting negedges from the one after capture.
   task automatic wait_done(output int k);
      k = 0;
      while (!done && k < 60) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic sb_check(input string name);
      logic [36:0] e;
      if (!done) begin
         chk({name, " done_timeout"}, 64'(done), 64'd1);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else if (exp_q.size() == 0) begin
         chk({name, " sb_empty"}, 64'(exp_q.size()), 64'd1);
      end else begin
         e = exp_q.pop_front();
         chk({name, " out"}, 64'({result, result_hi, flags, div_err}), 64'(e));
         chk({name, " busy_at_done"}, 64'(busy), 64'd0);
      end
   endtask

   // Issue one op starting on a negedge, check timing and outputs.
   task automatic do_op(input string name, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [36:0] e, input int lat);
      int k;
      @(negedge clk);
      start = 1'b1; opcode = op; op1 = a; op2 = b;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      chk({name, " busy_after_start"}, 64'({busy, done}), 64'b10);
      wait_done(k);
      chk({name, " latency"}, 64'(k), 64'(lat));
      sb_check(name);
      @(negedge clk);
      chk({name, " done_pulse_hold"}, 64'({done, result, result_hi, flags, div_err}),
          64'({1'b0, e}));
   endtask

   // ---------------- test ----------------
   initial begin
      logic [3:0]  rop;
      logic [15:0] ra, rb;
      logic [36:0] re;
      int          k;
      int          seen;

      rst_n = 1'b0; start = 1'b0; opcode = 4'h0; op1 = 16'h0; op2 = 16'h0;

      n_vec = 0;
      vecs[n_vec++] = '{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b0101, 1'b0, 1};
      vecs[n_vec++] = '{4'd1,  16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 4'b0110, 1'b0, 1};
      vecs[n_vec++] = '{4'd6,  16'h8001, 16'h0001, 16'h0002, 16'h0000, 4'b0010, 1'b0, 1};
      vecs[n_vec++] = '{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b1010, 1'b0, 1};
      vecs[n_vec++] = '{4'd2,  16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 4'b0000, 1'b0, 1};
      vecs[n_vec++] = '{4'd3,  16'h1200, 16'h0034, 16'h1234, 16'h0000, 4'b0000, 1'b0, 1};
      vecs[n_vec++] = '{4'd4,  16'hFF00, 16'h0FF0, 16'hF0F0, 16'h0000, 4'b0100, 1'b0, 1};
      vecs[n_vec++] = '{4'd5,  16'h00FF, 16'h1234, 16'hFF00, 16'h0000, 4'b0100, 1'b0, 1};
      vecs[n_vec++] = '{4'd7,  16'h8001, 16'h0001, 16'h4000, 16'h0000, 4'b0010, 1'b0, 1};
      vecs[n_vec++] = '{4'd6,  16'h1234, 16'h0000, 16'h1234, 16'h0000, 4'b0000, 1'b0, 1};
      vecs[n_vec++] = '{4'd1,  16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 4'b0001, 1'b0, 1};
      vecs[n_vec++] = '{4'd10, 16'h1111, 16'hABCD, 16'hABCD, 16'h0000, 4'b0100, 1'b0, 1};
      vecs[n_vec++] = '{4'd12, 16'h0005, 16'h0006, 16'h0000, 16'h0000, 4'b1000, 1'b0, 1};
      vecs[n_vec++] = '{4'd7,  16'h0001, 16'h0001, 16'h0000, 16'h0000, 4'b1010, 1'b0, 1};
      vecs[n_vec++] = '{4'd6,  16'h0001, 16'h000F, 16'h8000, 16'h0000, 4'b0100, 1'b0, 1};
      vecs[n_vec++] = '{4'd1,  16'h0005, 16'h0005, 16'h0000, 16'h0000, 4'b1000, 1'b0, 1};
      vecs[n_vec++] = '{4'd8,  16'h1234, 16'h0100, 16'h3400, 16'h0012, 4'b0011, 1'b0, 17};
      vecs[n_vec++] = '{4'd8,  16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0011, 1'b0, 17};
      vecs[n_vec++] = '{4'd8,  16'h0000, 16'h1234, 16'h0000, 16'h0000, 4'b1000, 1'b0, 17};
      vecs[n_vec++] = '{4'd9,  16'd100,  16'd7,    16'd14,   16'd2,    4'b0000, 1'b0, 17};
      vecs[n_vec++] = '{4'd9,  16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 4'b0100, 1'b0, 17};
      vecs[n_vec++] = '{4'd9,  16'h0005, 16'h0009, 16'h0000, 16'h0005, 4'b1000, 1'b0, 17};
      vecs[n_vec++] = '{4'd9,  16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 4'b0100, 1'b1, 1};
      vecs[n_vec++] = '{4'd15, 16'hAAAA, 16'h5555, 16'h0000, 16'h0000, 4'b1000, 1'b0, 1};

      // reset state
      #12;
      chk("reset_outputs", 64'({result, result_hi, flags, busy, done, div_err, dbg_state}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_release", 64'({busy, done, dbg_state}), 64'd0);

      // table
      for (int i = 0; i < n_vec; i++) begin
         do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
               pack_exp(vecs[i].res, vecs[i].hi, vecs[i].flg, vecs[i].err), vecs[i].lat);
      end

      // random ADD/SUB/MUL/DIVU against the behavioural model
      for (int i = 0; i < 12; i++) begin
         case ($urandom_range(0, 3))
            0: rop = 4'd0;
            1: rop = 4'd1;
            2: rop = 4'd8;
            default: rop = 4'd9;
         endcase
         ra = 16'($urandom_range(0, 65535));
         rb = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom_range(1, 65535));
         re = model(rop, ra, rb);
         do_op($sformatf("rand%0d", i), rop, ra, rb, re,
               ((rop == 4'd8) || (rop == 4'd9 && rb != 16'h0)) ? 17 : 1);
      end

      // MUL with an ignored start and operand changes mid-operation
      @(negedge clk);
      start = 1'b1; opcode = 4'd8; op1 = 16'h1234; op2 = 16'h0100;
      exp_q.push_back(pack_exp(16'h3400, 16'h0012, 4'b0011, 1'b0));
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!done && k < 60) begin
         @(negedge clk);
         k++;
         if (k == 5) begin
            start = 1'b1; opcode = 4'd0; op1 = 16'hFFFF; op2 = 16'hFFFF;
         end else if (k == 6) begin
            start = 1'b0;
         end
      end
      chk("mul_disturb latency", 64'(k), 64'd17);
      sb_check("mul_disturb");
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk("mul_disturb no_extra_done", 64'(seen), 64'd0);

      // reset in the middle of a MUL
      @(negedge clk);
      start = 1'b1; opcode = 4'd8; op1 = 16'hFFFF; op2 = 16'h00FF;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      chk("mid_reset busy_before", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_reset outputs", 64'({result, result_hi, flags, busy, done, div_err, dbg_state}), 64'd0);
      seen = 0;
      repeat (2) begin
         @(negedge clk);
         if (done) seen++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      chk("mid_reset no_done", 64'(seen), 64'd0);
      do_op("after_reset_add", 4'd0, 16'd2, 16'd3, pack_exp(16'd5, 16'h0, 4'b0000, 1'b0), 1);

      // back-to-back: start held in the done cycle
      @(negedge clk);
      start = 1'b1; opcode = 4'd0; op1 = 16'h0001; op2 = 16'h0002;
      exp_q.push_back(pack_exp(16'h0003, 16'h0, 4'b0000, 1'b0));
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("b2b first_done", 64'(done), 64'd1);
      sb_check("b2b_add");
      start = 1'b1; opcode = 4'd4; op1 = 16'hFF00; op2 = 16'h0FF0;
      exp_q.push_back(pack_exp(16'hF0F0, 16'h0, 4'b0100, 1'b0));
      @(negedge clk);
      start = 1'b0;
      chk("b2b accepted", 64'({busy, done}), 64'b10);
      @(negedge clk);
      chk("b2b second_done", 64'(done), 64'd1);
      sb_check("b2b_xor");

      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Sequential 16-bit ALU directly downstream of the operand registers (Op1/Op2). It consumes their held 16-bit outputs and executes one operation per start pulse. Single-cycle logic and arithmetic operations are included, plus iterative 16-step unsigned multiply and divide. Results and flags are registered and held for the accumulator/writeback path; busy and done give the controller a handshake.

Parameters:
WIDTH, 16, operand/result width (only 16 is verified)
ITER, 16, iteration count for MUL/DIV (must equal WIDTH)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
alu_start  in  1  request; sampled only while idle
alu_opcode  in  4  operation select, captured with start
alu_op1  in  16  operand 1 (from Op1 register)
alu_op2  in  16  operand 2 (from Op2 register)
alu_result  out  16  primary result / MUL low half / quotient
alu_result_hi  out  16  MUL high half / remainder; 0 for other ops
alu_flags  out  4  {Z,N,C,V}
alu_busy  out  1  high while an operation is in progress
alu_done  out  1  one-cycle pulse when the result is valid
alu_div_err  out  1  divide-by-zero, valid with done

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM to IDLE, iteration counter 0. Reset mid-operation aborts it with no done pulse.
- FSM states: IDLE, EXEC, ITER, FIN.
- IDLE: on start, capture opcode/op1/op2 at edge E0. Go to EXEC. busy=1 from E0.
- EXEC, single-cycle ops: result/flags registered at E1, done=1 for one cycle, busy=0, return to IDLE.
- EXEC, MUL/DIV (divisor != 0): initialise the datapath, go to ITER.
- ITER: one shift-add/restoring-subtract step per cycle for 16 cycles (edges E1..E16). Go to FIN.
- FIN: register results at E17, done pulse, busy=0, go to IDLE.
- MUL/DIV latency: done high in the cycle after E17.
- start while busy: ignored; the captured operands are unaffected by later operand changes.
- start asserted in the done cycle is accepted (FSM is already in IDLE), so operations can run back-to-back.
- Outputs hold their values until the next done. div_err clears at the next done.
- Opcodes:
  - 0 ADD
  - 1 SUB (op1-op2)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT op1
  - 6 SHL op1 by op2[3:0]
  - 7 SHR logical op1 by op2[3:0]
  - 8 MUL unsigned 32-bit
  - 9 DIVU (quotient, remainder)
  - 10 PASS op2
  - 11-15: result 0, flags Z=1 only, normal 2-cycle done
- Flags: Z = (result==0); N = result[15].
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = borrow (op1<op2 unsigned); V = signed overflow.
  - Shifts: C = last bit shifted out; C=0 for shift by 0; V=0.
  - MUL: C = V = (hi != 0).
  - DIV and logic ops: C = V = 0.
- Divide by zero: completes from EXEC like a single-cycle op (done after E1). result=16'hFFFF, result_hi=op1, div_err=1, Z=0, N=1, C=V=0.
- result_hi = 0 for all ops except MUL/DIV.

Decomposition:
- Package alu_pkg: opcode localparams (OP_ADD..OP_PASS), flag bit indices (FLG_Z=3, FLG_N=2, FLG_C=1, FLG_V=0), FSM state encoding, WIDTH default.
- One sub-module, alu_iter: the shared 32-bit shift register and 17-bit add/subtract datapath for MUL and DIV. It has init/step controls, a mode select, and hi/lo outputs. The top level keeps the FSM, the single-cycle ops and the output registers.

Test Plan:
- ADD 0x7FFF+0x0001 -> result 0x8000, flags Z0 N1 C0 V1, done exactly one cycle after E1, busy high for 1 cycle.
- SUB 0x0003-0x0005 -> 0xFFFE, N1 C1 V0; then SHL 0x8001 by 1 -> 0x0002, C1.
- MUL 0x1234*0x0100 -> result 0x3400, hi 0x0012, C1 V1, done after E17. A start pulse with ADD at cycle 5 is ignored and operands are changed mid-op; the result is unchanged.
- DIVU 100/7 -> 14 rem 2, div_err 0 (17-cycle latency); DIVU 0x1234/0 -> 0xFFFF, hi 0x1234, div_err 1, 2-cycle latency.
- rst_n low at iteration 8 of MUL -> all outputs 0 immediately, no done; after release, ADD 2+3 -> 5 normally.
- Back-to-back: start held in the done cycle of ADD with a new XOR 0xFF00^0x0FF0 -> second done one cycle later with 0xF0F0, N1.
